// File: rtl/step_pkg.sv
// Shared definitions for the pushbutton step-pulse front end: FSM state encoding
// and default timing for a 100 MHz system clock.
package step_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    HELD       = 3'd2,
    REPEAT     = 3'd3,
    RELEASE_DB = 3'd4
  } step_state_t;

  localparam int unsigned DEF_DB_CYCLES     = 1_000_000;   // 10 ms
  localparam int unsigned DEF_HOLD_CYCLES   = 50_000_000;  // 500 ms
  localparam int unsigned DEF_REPEAT_CYCLES = 10_000_000;  // 100 ms
  localparam int unsigned DEF_CNT_W         = 26;

endpackage

// File: rtl/sync_2ff.sv
// Reusable 1-bit double-flop synchronizer with asynchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // the pre-edge values and the chain really is two stages deep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/step_pulse_gen.sv
// Pushbutton conditioner: synchronize, debounce, and emit one step_mem pulse per
// press, with optional auto-repeat while the button stays held.
module step_pulse_gen
  import step_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  input  logic repeat_en,
  output logic step_mem,
  output logic btn_level
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  step_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             step_nxt, level_nxt;
  logic             btn_s;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (btn_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      step_mem  <= 1'b0;
      btn_level <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      step_mem  <= step_nxt;
      btn_level <= level_nxt;
    end
  end

  // Button-low exits are tested first so they win over any terminal count.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_nxt = state;
    case (state)
      IDLE:       if (btn_s) state_nxt = PRESS_DB;
      PRESS_DB:   if (!btn_s) state_nxt = IDLE;
                  else if (cnt == DB_LAST) state_nxt = HELD;
      HELD:       if (!btn_s) state_nxt = RELEASE_DB;
                  else if (repeat_en && cnt == HOLD_LAST) state_nxt = REPEAT;
      REPEAT:     if (!btn_s) state_nxt = RELEASE_DB;
                  else if (!repeat_en) state_nxt = HELD;
      RELEASE_DB: if (!btn_s && cnt == DB_LAST) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    step_nxt  = 1'b0;
    level_nxt = btn_level;
    cnt_nxt   = cnt;

    if (state_nxt != state) begin
      cnt_nxt = '0;
    end else begin
      case (state)
        PRESS_DB:   cnt_nxt = cnt + 1'b1;
        HELD:       if (repeat_en) cnt_nxt = cnt + 1'b1;
        REPEAT:     cnt_nxt = (cnt == REP_LAST) ? '0 : cnt + 1'b1;
        // Any high sample during release restarts the debounce window.
        RELEASE_DB: cnt_nxt = btn_s ? '0 : cnt + 1'b1;
        default:    cnt_nxt = '0;
      endcase
    end

    case (state)
      PRESS_DB: if (state_nxt == HELD) begin
        step_nxt  = 1'b1;
        level_nxt = 1'b1;
      end
      HELD:       if (state_nxt == REPEAT) step_nxt = 1'b1;
      REPEAT:     if (state_nxt == REPEAT && cnt == REP_LAST) step_nxt = 1'b1;
      RELEASE_DB: if (state_nxt == IDLE) level_nxt = 1'b0;
      default:    ;
    endcase
  end

endmodule

// File: doc/step_pulse_gen.md
# step_pulse_gen

Front-end conditioner for a board pushbutton that drives the address-step input of the memory dump counter. Synchronizes and debounces the raw button, then emits exactly one single-cycle `step_mem` pulse per press. Optional auto-repeat emits further pulses while the button is held. Output connects directly to the dump counter's `step_mem` input in the same `clk` domain.

## Interface
- `DB_CYCLES`, 1_000_000: required stable-level duration for press and release debounce (10 ms at 100 MHz).
- `HOLD_CYCLES`, 50_000_000: hold time after the first pulse before auto-repeat starts.
- `REPEAT_CYCLES`, 10_000_000: auto-repeat pulse period.
- `CNT_W`, 26: counter width; must hold max(parameter) − 1.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `btn_in`  in  1  raw pushbutton, asynchronous, bouncy, active-high.
- `repeat_en`  in  1  synchronous enable for auto-repeat.
- `step_mem`  out  1  registered one-cycle step pulse; reset value 0.
- `btn_level`  out  1  registered debounced button level; reset value 0.

## Operation
- `btn_in` passes through a 2-FF synchronizer (both FFs reset to 0). Its output is `btn_s`.
- A single `CNT_W`-bit counter is shared by all states. It is cleared on every state transition.
- IDLE: `btn_s`=1 → PRESS_DB.
- PRESS_DB: `btn_s`=0 → IDLE, bounce rejected, no pulse. Otherwise, when counter reaches DB_CYCLES−1 → HELD, `step_mem`=1 for one cycle, `btn_level`=1.
- HELD: `btn_s`=0 → RELEASE_DB. When `repeat_en`=1 and counter reaches HOLD_CYCLES−1 → REPEAT with a pulse. With `repeat_en`=0 the counter holds and no pulse is emitted.
- REPEAT: `btn_s`=0 → RELEASE_DB. `repeat_en`=0 → HELD with the counter cleared. When counter reaches REPEAT_CYCLES−1, pulse, clear counter, stay in REPEAT.
- RELEASE_DB: `btn_s`=1 clears the counter and stays, so bounce restarts the window. When `btn_s`=0 and counter reaches DB_CYCLES−1 → IDLE, `btn_level`=0. No pulse is ever produced on release.
- `step_mem` is never high on two consecutive cycles.
- Precedence when conditions coincide: `btn_s`=0 exit beats terminal count in the same cycle. In REPEAT, `repeat_en`=0 beats terminal count.
- Reset at any time forces IDLE, counter 0, synchronizer 0 and both outputs 0. A button still held when reset deasserts is treated as a new press: full debounce, then one pulse.

## Timing
- Edge 1 is the first rising edge with `btn_in` stable high.
  - Edges 1–2: synchronizer.
  - Edge 3: IDLE→PRESS_DB.
  - `step_mem` is high during the cycle after edge 3+DB_CYCLES.
- First repeat pulse: after edge 3+DB_CYCLES+HOLD_CYCLES.
- Subsequent repeat pulses: every REPEAT_CYCLES edges.
- Release: `btn_level` falls after edge 2+1+DB_CYCLES following the last `btn_in` high sample (2 sync + 1 transition + DB_CYCLES).
- Glitches shorter than DB_CYCLES+1 cycles produce no pulse and no `btn_level` change.

## Structure
- Shared package `step_pkg` holds:
  - 3-bit state encoding constants: IDLE, PRESS_DB, HELD, REPEAT, RELEASE_DB.
  - Default timing constants for 100 MHz.
- Sub-module `sync_2ff`: a reusable 1-bit double-flop synchronizer with async active-high reset.
- Top level contains the FSM, counter and output registers.

## Test plan
All scenarios use DB_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3.
- Clean press: `btn_in` high from edge 1 for 12 edges, `repeat_en`=0 → exactly one `step_mem` pulse after edge 7; `btn_level` 1 from edge 7 until release debounce completes; no pulse on release.
- Bounce: `btn_in` toggles 1,0,1,0 every 2 cycles, then stays high → no pulse during bouncing; one pulse 7 edges after the final stable rise.
- Auto-repeat: `repeat_en`=1, button held 30 edges → pulses after edges 7, 17, 20, 23, 26, 29. Clearing `repeat_en` at edge 21 stops pulses after 20.
- Release bounce: after a press, `btn_in` goes low, blips high for 1 cycle at low-cycle 2, then stays low → `btn_level` falls only after 4 continuous low `btn_s` cycles; no extra pulse.
- Reset mid-hold: assert `reset` during REPEAT with `btn_in` held → outputs 0 immediately (async); after deassert, one pulse 7 edges later.
